// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the universal shift register.
//   - usr_mode_e   : operation codes carried on cmd_mode (code 7 is reserved)
//   - usr_state_t  : FSM state type with ST_IDLE / ST_SHIFT constants
//   - is_multi_step: true for modes whose step count comes from cmd_count
// Optional feature macro: USR_ROTATE_EN (enables ROR/ROL as counted modes).
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_SHL  = 3'd3,
        MODE_ROR  = 3'd4,
        MODE_ROL  = 3'd5,
        MODE_CLR  = 3'd6
    } usr_mode_e;

    typedef logic [0:0] usr_state_t;
    localparam usr_state_t ST_IDLE  = 1'b0;
    localparam usr_state_t ST_SHIFT = 1'b1;

    // Counted modes honour cmd_count; everything else is a single step.
    // Without rotate support, ROR/ROL fall back to single-step HOLD.
    function automatic logic is_multi_step(input logic [2:0] mode);
`ifdef USR_ROTATE_EN
        return (mode == MODE_SHR) || (mode == MODE_SHL) ||
               (mode == MODE_ROR) || (mode == MODE_ROL);
`else
        return (mode == MODE_SHR) || (mode == MODE_SHL);
`endif
    endfunction

endpackage

// File: rtl/usr_step.sv
// usr_step: combinational one-step next-value function of the shift register.
// Ports:
//   mode        in  3      operation code (usr_mode_e encoding)
//   q           in  WIDTH  current register contents
//   sin_r/sin_l in  1      serial inputs for right/left shift
//   sout_r/sout_l in 1     current serial output registers
//   q_next      out WIDTH  register value after one step
//   sout_r_next/sout_l_next out 1  serial outputs after one step
// Optional feature macro: USR_ROTATE_EN (rotate datapath only built when set).
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] q,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             sout_r,
    input  logic             sout_l,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q_next,
    output logic             sout_r_next,
    output logic             sout_l_next
);

    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;
`ifdef USR_ROTATE_EN
    logic [WIDTH-1:0] ror_vec;
    logic [WIDTH-1:0] rol_vec;
`endif

    // Per-bit neighbour wiring; the end bits take the serial input or,
    // for rotates, the bit falling off the opposite end.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            if (gi == WIDTH - 1) begin : g_msb
                assign shr_vec[gi] = sin_r;
`ifdef USR_ROTATE_EN
                assign ror_vec[gi] = q[0];
`endif
            end else begin : g_not_msb
                assign shr_vec[gi] = q[gi+1];
`ifdef USR_ROTATE_EN
                assign ror_vec[gi] = q[gi+1];
`endif
            end
            if (gi == 0) begin : g_lsb
                assign shl_vec[gi] = sin_l;
`ifdef USR_ROTATE_EN
                assign rol_vec[gi] = q[WIDTH-1];
`endif
            end else begin : g_not_lsb
                assign shl_vec[gi] = q[gi-1];
`ifdef USR_ROTATE_EN
                assign rol_vec[gi] = q[gi-1];
`endif
            end
        end
    endgenerate

    always_comb begin
        q_next      = q;
        sout_r_next = sout_r;
        sout_l_next = sout_l;
        case (mode)
            MODE_LOAD: q_next = load_data;
            MODE_CLR:  q_next = '0;
            MODE_SHR: begin
                q_next      = shr_vec;
                sout_r_next = q[0];
            end
            MODE_SHL: begin
                q_next      = shl_vec;
                sout_l_next = q[WIDTH-1];
            end
`ifdef USR_ROTATE_EN
            MODE_ROR:  q_next = ror_vec;
            MODE_ROL:  q_next = rol_vec;
`endif
            default:   q_next = q;   // HOLD, reserved code, disabled rotates
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: parametrised register with load, clear, counted
// right/left shift (separate serial ins/outs) and optional rotate. A command
// is accepted when cmd_valid && cmd_ready; counted modes execute one step per
// clock for min(cmd_count, WIDTH) steps, the accept edge being step 1.
// Ports:
//   clock, clear          clock and asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_mode, cmd_count   operation code and step count
//   load_data             parallel data for LOAD
//   sin_r, sin_l          serial inputs (enter at MSB / LSB)
//   q                     register contents
//   sout_r, sout_l        last bit shifted out of LSB / MSB
//   busy                  counted command still stepping
//   done                  one-cycle completion pulse, cycle after last step
// Optional feature macro: USR_ROTATE_EN (ROR/ROL; otherwise they act as HOLD).
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] load_data,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    usr_state_t       state_reg, state_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [2:0]       mode_reg, mode_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             sout_r_reg, sout_r_next;
    logic             sout_l_reg, sout_l_next;
    logic             done_reg, done_next;

    logic             accept;
    logic [CNT_W-1:0] n_eff;
    logic             step_en;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] q_step;
    logic             sout_r_step;
    logic             sout_l_step;

    assign accept = cmd_valid && (state_reg == ST_IDLE);
    assign n_eff  = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;

    usr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode        (step_mode),
        .q           (q_reg),
        .sin_r       (sin_r),
        .sin_l       (sin_l),
        .sout_r      (sout_r_reg),
        .sout_l      (sout_l_reg),
        .load_data   (load_data),
        .q_next      (q_step),
        .sout_r_next (sout_r_step),
        .sout_l_next (sout_l_step)
    );

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        mode_next      = mode_reg;
        done_next      = 1'b0;
        step_en        = 1'b0;
        step_mode      = mode_reg;
        case (state_reg)
            ST_IDLE: begin
                step_mode = cmd_mode;
                if (accept) begin
                    mode_next = cmd_mode;
                    if (is_multi_step(cmd_mode)) begin
                        // A zero count still completes, just without a step.
                        step_en = (n_eff != '0);
                        if (n_eff > CNT_W'(1)) begin
                            state_next     = ST_SHIFT;
                            remaining_next = n_eff - CNT_W'(1);
                        end else begin
                            done_next = 1'b1;
                        end
                    end else begin
                        step_en   = 1'b1;
                        done_next = 1'b1;
                    end
                end
            end
            default: begin
                step_en        = 1'b1;
                remaining_next = remaining_reg - CNT_W'(1);
                if (remaining_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
        endcase
    end

    assign q_next      = step_en ? q_step      : q_reg;
    assign sout_r_next = step_en ? sout_r_step : sout_r_reg;
    assign sout_l_next = step_en ? sout_l_step : sout_l_reg;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            mode_reg      <= 3'd0;
            q_reg         <= '0;
            sout_r_reg    <= 1'b0;
            sout_l_reg    <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            mode_reg      <= mode_next;
            q_reg         <= q_next;
            sout_r_reg    <= sout_r_next;
            sout_l_reg    <= sout_l_next;
            done_reg      <= done_next;
        end
    end

    assign q         = q_reg;
    assign sout_r    = sout_r_reg;
    assign sout_l    = sout_l_reg;
    assign done      = done_reg;
    assign busy      = (state_reg == ST_SHIFT);
    assign cmd_ready = (state_reg == ST_IDLE);

endmodule

// File: tb/tb_universal_shift_register.sv
// Testbench for universal_shift_register (WIDTH=8): a table of hand-computed
// command results, a mid-command clear sequence, and randomized commands
// compared against an arithmetic reference model. Honours USR_ROTATE_EN.
module tb_universal_shift_register;
    import usr_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clock;
    logic          clear;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_mode;
    logic [CW-1:0] cmd_count;
    logic [W-1:0]  load_data;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  q;
    logic          sout_r;
    logic          sout_l;
    logic          busy;
    logic          done;

    universal_shift_register #(.WIDTH(W)) dut (
        .clock     (clock),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_count (cmd_count),
        .load_data (load_data),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .q         (q),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [W-1:0] m_q;
    logic         m_sr;
    logic         m_sl;

    typedef struct {
        logic [2:0] mode;
        int         count;
        logic [W-1:0] data;
        logic       sr;
        logic       sl;
        logic [W-1:0] exp_q;
        logic       exp_sout_r;
        logic       exp_sout_l;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Number of register updates a command causes.
    function automatic int steps_of(input logic [2:0] mode, input int count);
        int n;
        n = (count > W) ? W : count;
        if (mode == MODE_SHR || mode == MODE_SHL) return n;
`ifdef USR_ROTATE_EN
        if (mode == MODE_ROR || mode == MODE_ROL) return n;
`endif
        return 1;
    endfunction

    task automatic model_step(input logic [2:0] mode, input logic [W-1:0] data,
                              input logic sr, input logic sl);
        case (mode)
            MODE_LOAD: m_q = data;
            MODE_CLR:  m_q = '0;
            MODE_SHR: begin
                m_sr = m_q[0];
                m_q  = (m_q >> 1) | (W'(sr) << (W - 1));
            end
            MODE_SHL: begin
                m_sl = m_q[W-1];
                m_q  = (m_q << 1) | W'(sl);
            end
`ifdef USR_ROTATE_EN
            MODE_ROR: m_q = (m_q >> 1) | (m_q << (W - 1));
            MODE_ROL: m_q = (m_q << 1) | (m_q >> (W - 1));
`endif
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, "_q"},      64'(q),         64'(m_q));
        chk({tag, "_sout_r"}, 64'(sout_r),    64'(m_sr));
        chk({tag, "_sout_l"}, 64'(sout_l),    64'(m_sl));
        chk({tag, "_busy"},   64'(busy),      64'(exp_busy));
        chk({tag, "_done"},   64'(done),      64'(exp_done));
        chk({tag, "_ready"},  64'(cmd_ready), 64'(!exp_busy));
    endtask

    // Issue one command at the current sample point and follow it to its
    // done cycle. Returns with the next command slot available immediately.
    task automatic do_cmd(input logic [2:0] mode, input int count, input logic [W-1:0] data,
                          input bit rand_sin, input logic sr_fix, input logic sl_fix,
                          input bit noise, output int cycles);
        int   steps;
        int   last;
        logic sr;
        logic sl;
        steps = steps_of(mode, count);
        last  = (steps > 1) ? steps - 1 : 0;
        chk("issue_ready", 64'(cmd_ready), 64'(1));
        for (int j = 0; j <= last; j++) begin
            sr = rand_sin ? 1'($urandom_range(0, 1)) : sr_fix;
            sl = rand_sin ? 1'($urandom_range(0, 1)) : sl_fix;
            sin_r = sr;
            sin_l = sl;
            if (j == 0) begin
                cmd_valid = 1'b1;
                cmd_mode  = mode;
                cmd_count = CW'(count);
                load_data = data;
            end else begin
                // Garbage requests while shifting must be ignored.
                cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                cmd_mode  = 3'($urandom_range(0, 7));
                cmd_count = CW'($urandom);
                load_data = W'($urandom);
            end
            @(posedge clock);
            #1;
            if (j < steps) model_step(mode, data, sr, sl);
            check_outputs("cmd", j < last, j == last);
        end
        cmd_valid = 1'b0;
        cycles = last + 1;
    endtask

    task automatic idle_cycle();
        cmd_valid = 1'b0;
        sin_r     = 1'($urandom_range(0, 1));
        sin_l     = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
        check_outputs("idle", 1'b0, 1'b0);
    endtask

    initial begin
        int cyc;
        clear     = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 3'd0;
        cmd_count = '0;
        load_data = '0;
        sin_r     = 1'b0;
        sin_l     = 1'b0;
        m_q  = '0;
        m_sr = 1'b0;
        m_sl = 1'b0;

        // Hand-computed table; rows chain from the reset state.
        vecs[0]  = '{MODE_LOAD, 0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1};
        vecs[1]  = '{MODE_SHR,  3, 8'h00, 1'b1, 1'b0, 8'hF4, 1'b1, 1'b0, 3};
        vecs[2]  = '{MODE_LOAD, 0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 1};
        vecs[3]  = '{MODE_SHL,  9, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8};
        vecs[4]  = '{MODE_LOAD, 0, 8'h12, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, 1};
`ifdef USR_ROTATE_EN
        vecs[5]  = '{MODE_ROL,  4, 8'h00, 1'b0, 1'b0, 8'h21, 1'b1, 1'b1, 4};
`else
        vecs[5]  = '{MODE_ROL,  4, 8'h00, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, 1};
`endif
        vecs[6]  = '{MODE_LOAD, 0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1};
        vecs[7]  = '{MODE_SHR,  0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1};
        vecs[8]  = '{3'd7,      5, 8'hFF, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1};
        vecs[9]  = '{MODE_SHR,  2, 8'h00, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 2};
        vecs[10] = '{MODE_LOAD, 0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1};
        vecs[11] = '{MODE_CLR,  3, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1};
        vecs[12] = '{MODE_SHL,  1, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1};

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_outputs("reset", 1'b0, 1'b0);
        clear = 1'b0;
        idle_cycle();

        // Table: commands issued back to back, no idle gaps.
        for (int i = 0; i < 13; i++) begin
            do_cmd(vecs[i].mode, vecs[i].count, vecs[i].data, 1'b0,
                   vecs[i].sr, vecs[i].sl, 1'b1, cyc);
            chk($sformatf("vec%0d_q", i),      64'(q),      64'(vecs[i].exp_q));
            chk($sformatf("vec%0d_sout_r", i), 64'(sout_r), 64'(vecs[i].exp_sout_r));
            chk($sformatf("vec%0d_sout_l", i), 64'(sout_l), 64'(vecs[i].exp_sout_l));
            chk($sformatf("vec%0d_cycles", i), 64'(cyc),    64'(vecs[i].exp_cycles));
            $display("vec %0d mode=%0d count=%0d q=%02h sout_r=%0b sout_l=%0b cycles=%0d",
                     i, vecs[i].mode, vecs[i].count, q, sout_r, sout_l, cyc);
        end
        idle_cycle();

        // Clear in the middle of SHR count 5, right after step 2.
        do_cmd(MODE_LOAD, 0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
        cmd_valid = 1'b1;
        cmd_mode  = MODE_SHR;
        cmd_count = CW'(5);
        sin_r     = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_busy_before", 64'(busy), 64'(1));
        clear = 1'b1;
        #1;
        m_q  = '0;
        m_sr = 1'b0;
        m_sl = 1'b0;
        check_outputs("abort", 1'b0, 1'b0);
        #1;
        clear = 1'b0;
        repeat (4) idle_cycle();
        do_cmd(MODE_LOAD, 0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, cyc);
        chk("after_abort_q", 64'(q), 64'(8'h5A));
        $display("clear abort sequence q=%02h", q);

        // Randomized commands against the reference model.
        for (int k = 0; k < 300; k++) begin
            logic [2:0]   rm;
            int           rc;
            logic [W-1:0] rd;
            rm = 3'($urandom_range(0, 7));
            rc = $urandom_range(0, (1 << CW) - 1);
            rd = W'($urandom);
            do_cmd(rm, rc, rd, 1'b1, 1'b0, 1'b0, 1'b1, cyc);
            $display("rand %0d mode=%0d count=%0d q=%02h cycles=%0d", k, rm, rc, q, cyc);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
